rv32_fetch_controller: RTL and testbench
========================================

# rv32_fetch_controller

Front-end sequencer for the RV32 pipeline. It owns the fetch program counter, drives the instruction-memory request, and produces the flush and PC-of-decode signals consumed by the decode-stage instruction mux. It resolves redirects (trap, mret, branch/jump) by priority, injects NOP bubbles on memory wait and wrong-path fetches, and parks the front end on WFI.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_in  input  1  core clock, all state on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- stall_in  input  1  downstream hazard stall; hold fetch and decode
- branch_taken_in  input  1  EX-stage taken branch/jump
- branch_target_in  input  32  branch/jump target
- trap_in  input  1  trap/interrupt taken
- trap_vector_in  input  32  trap handler address
- mret_in  input  1  return from trap
- epc_in  input  32  mret return address
- wfi_in  input  1  WFI retired; park front end
- imem_ready_in  input  1  memory accepted the request this cycle; data valid next cycle
- imem_req_out  output  1  fetch request
- imem_addr_out  output  32  fetch address (= pc_q)
- pc_if_out  output  32  address of the instruction currently on the mux input
- flush_out  output  1  to mux flush input; 1 selects NOP 32'h0000_0013
- halted_out  output  1  front end parked in S_HALT
- misaligned_out  output  1  misaligned redirect detected (macro-dependent)

## Operation
- States: S_RESET, S_FETCH, S_HALT.
- S_RESET: entered asynchronously on rst_n_in=0. Exits to S_FETCH on the first rising edge with rst_n_in=1. imem_req_out=0.
- S_FETCH: imem_req_out = ~stall_in. Accept = imem_req_out & imem_ready_in.
  - On accept without redirect: pc_if_q<=pc_q, valid_q<=1, pc_q<=pc_q+4 (wraps modulo 2^32).
  - Without accept: valid_q<=0 unless stall_in, in which case valid_q and pc_if_q hold.
- Redirect priority: trap_in > mret_in > branch_taken_in. Selected target goes to pc_q; valid_q<=0. The in-flight memory response is discarded. Redirect overrides stall_in.
- wfi_in (no simultaneous redirect): S_FETCH->S_HALT, valid_q<=0, pc_q holds the next sequential address.
- S_HALT: imem_req_out=0, halted_out=1. trap_in exits to S_FETCH with pc_q<=trap_vector_in. mret_in and branch_taken_in are ignored.
- flush_out = (state!=S_FETCH) | ~valid_q | trap_in | mret_in | branch_taken_in. Combinational on redirect inputs so the wrong-path instruction in decode is killed in the same cycle.
- During stall_in, the memory holds read data, and the controller holds pc_if_q, valid_q and pc_q.

## Timing
- Reset values: pc_q=RESET_PC, pc_if_q=RESET_PC, valid_q=0, imem_req_out=0, flush_out=1, halted_out=0, misaligned_out=0.
- Fetch latency: request accepted in cycle N -> instruction on mux with flush_out=0 in N+1. Throughput 1 instr/cycle with imem_ready_in held high.
- Redirect in cycle N: flush_out=1 in N and N+1. Target requested in N+1, first target instruction decoded in N+2. Penalty: 2 bubbles.
- Simultaneous trap_in and wfi_in: trap wins, stays in S_FETCH.
- Reset mid-operation: immediate return to reset values, regardless of state.

## Configuration
- RV32_FETCH_MISALIGN_TRAP_EN defined: a redirect target with [1:0]!=0 pulses misaligned_out for one cycle.
  - pc_q is not updated and valid_q<=0.
  - The controller waits for the core's trap_in.
  - Trap-vector targets are exempt.
- Not defined: target[1:0] is forced to 2'b00, and misaligned_out is tied 0.

## Test plan
- Reset release, RESET_PC=32'h100, imem_ready_in=1 -> imem_addr_out 100,104,108 on successive cycles. flush_out=1 until the cycle after the first accept, then pc_if_out=100 with flush_out=0.
- Branch in steady state, branch_taken_in=1, target 32'h200 at cycle N -> flush_out=1 in N and N+1, imem_addr_out=200 in N+1, pc_if_out=200 with flush_out=0 in N+2.
- imem_ready_in low for 3 cycles -> 3 extra flush_out=1 cycles, pc_q unchanged. stall_in for 2 cycles -> pc_if_out and flush_out=0 held, imem_req_out=0.
- trap_in, mret_in and branch_taken_in asserted together, trap_vector_in=32'h80 -> imem_addr_out=80 next cycle.
- wfi_in -> halted_out=1 and imem_req_out=0 for 10 cycles. branch_taken_in is ignored. trap_in with vector 32'h40 -> S_FETCH, imem_addr_out=40.
- Branch target 32'h202: with the macro, misaligned_out pulses 1 cycle and pc_q is unchanged. Without the macro, imem_addr_out=200.

Source files
------------

// File: rtl/rv32_fetch_controller.sv
// rv32_fetch_controller: RV32 front-end sequencer.
// Owns the fetch PC, drives the instruction-memory request, and tells the
// decode-stage mux when to substitute a NOP (flush_out) and which PC the
// decoded instruction belongs to (pc_if_out).
// Redirect priority is trap > mret > branch. WFI parks the front end in
// S_HALT until a trap arrives.
// Optional feature macro: RV32_FETCH_MISALIGN_TRAP_EN
//   defined   : a non-trap redirect to a target with [1:0]!=0 is refused,
//               misaligned_out pulses for one cycle and the core is expected
//               to follow up with trap_in.
//   undefined : redirect targets are word-aligned by clearing [1:0] and
//               misaligned_out is tied low.

module rv32_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        trap_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        wfi_in,
    input  logic        imem_ready_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] pc_if_out,
    output logic        flush_out,
    output logic        halted_out,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pc_if;
    logic [31:0] w_pc_if_nxt;
    logic        r_valid;
    logic        w_valid_nxt;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic        w_mis_detect;
    logic        w_accept;

    assign w_redirect = trap_in | mret_in | branch_taken_in;

    // Select the redirect target by priority: trap, then mret, then branch.
    always_comb begin
        if (trap_in) begin
            w_target_raw = trap_vector_in;
        end else if (mret_in) begin
            w_target_raw = epc_in;
        end else begin
            w_target_raw = branch_target_in;
        end
    end

`ifdef RV32_FETCH_MISALIGN_TRAP_EN
    // Trap vectors are exempt: only mret/branch targets can be refused.
    assign w_target     = w_target_raw;
    assign w_mis_detect = w_redirect & ~trap_in & (w_target_raw[1:0] != 2'b00);
`else
    assign w_target     = w_target_raw & ~32'h0000_0003;
    assign w_mis_detect = 1'b0;
`endif

    // Next-state, next-PC and request/flush outputs for the front-end FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave one
        // unassigned, which would otherwise infer a latch.
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pc_if_nxt  = r_pc_if;
        w_valid_nxt  = r_valid;
        imem_req_out = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            S_RESET: begin
                w_state_nxt = S_FETCH;
                w_valid_nxt = 1'b0;
            end

            S_FETCH: begin
                imem_req_out = ~stall_in;
                w_accept     = ~stall_in & imem_ready_in;
                if (w_redirect) begin
                    // Any in-flight response belongs to the wrong path.
                    w_valid_nxt = 1'b0;
                    if (!w_mis_detect) begin
                        w_pc_nxt = w_target;
                    end
                end else if (wfi_in) begin
                    // Park with pc_q already pointing at the next sequential fetch.
                    w_state_nxt = S_HALT;
                    w_valid_nxt = 1'b0;
                end else if (w_accept) begin
                    w_pc_if_nxt = r_pc;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + 32'd4;
                end else if (!stall_in) begin
                    w_valid_nxt = 1'b0;
                end
            end

            S_HALT: begin
                w_valid_nxt = 1'b0;
                if (trap_in) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = w_target;
                end
            end

            default: begin
                w_state_nxt = S_RESET;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, fetch PC, decode PC and decode-valid registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_RESET;
            r_pc    <= RESET_PC;
            r_pc_if <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pc_if <= w_pc_if_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef RV32_FETCH_MISALIGN_TRAP_EN
    logic r_misaligned;

    // One-cycle pulse following a refused misaligned redirect.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= (r_state == S_FETCH) & w_mis_detect;
        end
    end

    assign misaligned_out = r_misaligned;
`else
    assign misaligned_out = 1'b0;
`endif

    assign imem_addr_out = r_pc;
    assign pc_if_out     = r_pc_if;
    assign halted_out    = (r_state == S_HALT);
    // Redirect inputs feed flush directly so the wrong-path instruction now in
    // decode is killed in the same cycle the redirect is seen.
    assign flush_out     = (r_state != S_FETCH) | ~r_valid | w_redirect;

endmodule

// File: tb/tb_rv32_fetch_controller.sv
// Self-checking bench for rv32_fetch_controller (RESET_PC = 32'h100).
// A behavioural model of the fetch front end is compared against the DUT on
// every falling clock edge; directed literal checks pin the model to
// hand-computed addresses from the test plan.

module tb_rv32_fetch_controller;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        trap_in;
    logic [31:0] trap_vector_in;
    logic        mret_in;
    logic [31:0] epc_in;
    logic        wfi_in;
    logic        imem_ready_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic [31:0] pc_if_out;
    logic        flush_out;
    logic        halted_out;
    logic        misaligned_out;

    int n_pass  = 0;
    int n_total = 0;

    rv32_fetch_controller #(.RESET_PC(RPC)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .stall_in        (stall_in),
        .branch_taken_in (branch_taken_in),
        .branch_target_in(branch_target_in),
        .trap_in         (trap_in),
        .trap_vector_in  (trap_vector_in),
        .mret_in         (mret_in),
        .epc_in          (epc_in),
        .wfi_in          (wfi_in),
        .imem_ready_in   (imem_ready_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .pc_if_out       (pc_if_out),
        .flush_out       (flush_out),
        .halted_out      (halted_out),
        .misaligned_out  (misaligned_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: 0 = coming out of reset, 1 = running, 2 = parked on WFI.
    int          m_phase;
    logic [31:0] m_fetch_pc;   // next address the front end will request
    logic [31:0] m_dec_pc;     // PC of the instruction sitting in decode
    logic        m_dec_live;   // decode holds a real, right-path instruction
    logic        m_mis;

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        if (trap_in)      t = trap_vector_in;
        else if (mret_in) t = epc_in;
        else              t = branch_target_in;
        return t;
    endfunction

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_phase    <= 0;
            m_fetch_pc <= RPC;
            m_dec_pc   <= RPC;
            m_dec_live <= 1'b0;
            m_mis      <= 1'b0;
        end else begin
            m_mis <= 1'b0;
            if (m_phase == 0) begin
                m_phase <= 1;
            end else if (m_phase == 1) begin
                if (trap_in || mret_in || branch_taken_in) begin
                    m_dec_live <= 1'b0;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
                    if (!trap_in && (pick_target() % 4 != 0)) m_mis <= 1'b1;
                    else                                      m_fetch_pc <= pick_target();
`else
                    m_fetch_pc <= pick_target() - (pick_target() % 4);
`endif
                end else if (wfi_in) begin
                    m_phase    <= 2;
                    m_dec_live <= 1'b0;
                end else if (!stall_in && imem_ready_in) begin
                    m_dec_pc   <= m_fetch_pc;
                    m_dec_live <= 1'b1;
                    m_fetch_pc <= m_fetch_pc + 4;
                end else if (!stall_in) begin
                    m_dec_live <= 1'b0;
                end
            end else if (trap_in) begin
                m_phase    <= 1;
                m_fetch_pc <= trap_vector_in - (trap_vector_in % 4);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk_in) begin
        if (n_total > 0) begin
            check("m_req",   {31'd0, imem_req_out}, {31'd0, (m_phase == 1) && !stall_in});
            check("m_addr",  imem_addr_out, m_fetch_pc);
            check("m_pc_if", pc_if_out, m_dec_pc);
            check("m_flush", {31'd0, flush_out},
                  {31'd0, (m_phase != 1) || !m_dec_live || trap_in || mret_in || branch_taken_in});
            check("m_halt",  {31'd0, halted_out}, {31'd0, m_phase == 2});
            check("m_mis",   {31'd0, misaligned_out}, {31'd0, m_mis});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_n_in = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0; branch_target_in = '0;
        trap_in = 1'b0; trap_vector_in = '0; mret_in = 1'b0; epc_in = '0;
        wfi_in = 1'b0; imem_ready_in = 1'b1;
        #2 rst_n_in = 1'b0;

        // Reset state
        cyc(); #2;
        check("rst_addr",  imem_addr_out, RPC);
        check("rst_pc_if", pc_if_out, RPC);
        check("rst_req",   {31'd0, imem_req_out}, 32'd0);
        check("rst_flush", {31'd0, flush_out}, 32'd1);
        check("rst_halt",  {31'd0, halted_out}, 32'd0);
        check("rst_mis",   {31'd0, misaligned_out}, 32'd0);
        cyc(); rst_n_in = 1'b1;

        // Sequential fetch 100,104,108
        cyc(); #2;
        check("f0_addr",  imem_addr_out, 32'h100);
        check("f0_req",   {31'd0, imem_req_out}, 32'd1);
        check("f0_flush", {31'd0, flush_out}, 32'd1);
        cyc(); #2;
        check("f1_addr",  imem_addr_out, 32'h104);
        check("f1_pc_if", pc_if_out, 32'h100);
        check("f1_flush", {31'd0, flush_out}, 32'd0);
        cyc(); #2;
        check("f2_addr",  imem_addr_out, 32'h108);
        check("f2_pc_if", pc_if_out, 32'h104);

        // Branch to 200
        branch_taken_in = 1'b1; branch_target_in = 32'h200; #1;
        check("br_flush_n", {31'd0, flush_out}, 32'd1);
        cyc(); branch_taken_in = 1'b0; #2;
        check("br_addr",     imem_addr_out, 32'h200);
        check("br_flush_n1", {31'd0, flush_out}, 32'd1);
        cyc(); #2;
        check("br_pc_if",  pc_if_out, 32'h200);
        check("br_flush2", {31'd0, flush_out}, 32'd0);
        check("br_addr2",  imem_addr_out, 32'h204);

        // Memory not ready for 3 cycles
        imem_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            check("nr_addr",  imem_addr_out, 32'h204);
            check("nr_flush", {31'd0, flush_out}, 32'd1);
        end
        imem_ready_in = 1'b1;
        cyc(); #2;
        check("nr_pc_if", pc_if_out, 32'h204);
        check("nr_done",  {31'd0, flush_out}, 32'd0);

        // Stall for 2 cycles
        stall_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("st_req",   {31'd0, imem_req_out}, 32'd0);
            check("st_pc_if", pc_if_out, 32'h204);
            check("st_flush", {31'd0, flush_out}, 32'd0);
            check("st_addr",  imem_addr_out, 32'h208);
            cyc();
        end
        stall_in = 1'b0; #2;
        check("st_req_back", {31'd0, imem_req_out}, 32'd1);
        cyc(); #2;
        check("st_pc_if2", pc_if_out, 32'h208);

        // trap + mret + branch together: trap wins
        trap_in = 1'b1; mret_in = 1'b1; branch_taken_in = 1'b1;
        trap_vector_in = 32'h80; epc_in = 32'h300; branch_target_in = 32'h400;
        cyc(); trap_in = 1'b0; mret_in = 1'b0; branch_taken_in = 1'b0; #2;
        check("prio_addr", imem_addr_out, 32'h80);
        cyc(); #2;
        check("prio_pc_if", pc_if_out, 32'h80);

        // WFI parks; branches ignored; trap to 40 resumes
        wfi_in = 1'b1;
        cyc(); wfi_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            branch_taken_in = (i % 3 == 0); branch_target_in = 32'h500;
            #2;
            check("wfi_halt", {31'd0, halted_out}, 32'd1);
            check("wfi_req",  {31'd0, imem_req_out}, 32'd0);
            check("wfi_addr", imem_addr_out, 32'h84);
            cyc();
        end
        branch_taken_in = 1'b0;
        trap_in = 1'b1; trap_vector_in = 32'h40;
        cyc(); trap_in = 1'b0; #2;
        check("wake_halt", {31'd0, halted_out}, 32'd0);
        check("wake_addr", imem_addr_out, 32'h40);
        cyc(); #2;
        check("wake_pc_if", pc_if_out, 32'h40);

        // Misaligned branch target
        branch_taken_in = 1'b1; branch_target_in = 32'h202;
        cyc(); branch_taken_in = 1'b0; #2;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
        check("mis_pulse", {31'd0, misaligned_out}, 32'd1);
        check("mis_addr",  imem_addr_out, 32'h44);
        cyc(); #2;
        check("mis_clear", {31'd0, misaligned_out}, 32'd0);
`else
        check("mis_addr",  imem_addr_out, 32'h200);
        check("mis_tied",  {31'd0, misaligned_out}, 32'd0);
`endif
        cyc();

        // trap + wfi together: trap wins, stays fetching
        trap_in = 1'b1; wfi_in = 1'b1; trap_vector_in = 32'h80;
        cyc(); trap_in = 1'b0; wfi_in = 1'b0; #2;
        check("tw_halt", {31'd0, halted_out}, 32'd0);
        check("tw_addr", imem_addr_out, 32'h80);
        cyc(); cyc();

        // Asynchronous reset mid-operation
        #1 rst_n_in = 1'b0; #1;
        check("ar_addr",  imem_addr_out, RPC);
        check("ar_pc_if", pc_if_out, RPC);
        check("ar_req",   {31'd0, imem_req_out}, 32'd0);
        check("ar_flush", {31'd0, flush_out}, 32'd1);
        cyc(); rst_n_in = 1'b1;
        cyc(); #2;
        check("ar_req2",  {31'd0, imem_req_out}, 32'd1);
        cyc(); #2;
        check("ar_pc_if2", pc_if_out, RPC);
        check("ar_flush2", {31'd0, flush_out}, 32'd0);

        cyc(); cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
